// File: rtl/fp_pkg.sv
// fp_pkg: rounding-mode codes, FSM encoding and IEEE pattern helper for the FP multiplier
package fp_pkg;
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RZ  = 3'd1;
  localparam logic [2:0] RM_RD  = 3'd2;
  localparam logic [2:0] RM_RU  = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_NORM = 3'd2,
    S_RND  = 3'd3,
    S_FIN  = 3'd4
  } state_t;
  typedef enum logic [1:0] {PAT_NAN, PAT_INF, PAT_MAX} pat_t;
  function automatic logic [63:0] fp_pat(input int ew, input int mw, input pat_t kind, input logic sign);
    logic [63:0] e;
    e = ((64'd1 << ew) - 64'd1) << mw;
    return ({63'd0, sign} << (ew + mw)) | (kind == PAT_NAN ? (e | (64'd1 << (mw - 1))) :
      kind == PAT_INF ? e : ((e - (64'd1 << mw)) | ((64'd1 << mw) - 64'd1)));
  endfunction
endpackage

// File: rtl/fp_mant_mul_seq.sv
// fp_mant_mul_seq: shift-add mantissa multiplier; the first bit is consumed on the start edge
module fp_mant_mul_seq #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  logic [2*N-1:0] a_sh;
  logic [N-1:0] b_sh;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      p <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        p <= b[0] ? {{N{1'b0}}, a} : '0;
        a_sh <= {{(N-1){1'b0}}, a, 1'b0};
        b_sh <= b >> 1;
        cnt <= CW'(1);
        busy <= 1'b1;
      end else if (busy) begin
        p <= p + (b_sh[0] ? a_sh : '0);
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt <= cnt + CW'(1);
        busy <= cnt != LAST;
        done <= cnt == LAST;
      end
    end
  end
endmodule

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multicycle IEEE-754 multiplier with subnormal flush, five rounding modes and IEEE flags
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23,
  localparam int W = 1 + EW + MW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact
);
  localparam int N = MW + 1;
  localparam int BIAS = 2 ** (EW - 1) - 1;
  state_t state;
  logic s1, s2, nan1, nan2, inf1, inf2, zero1, zero2, special, inv_op, accept, mul_busy, mul_done;
  logic [EW-1:0] e1, e2;
  logic [MW-1:0] m1, m2;
  logic [W-1:0] sp_res, rnd_res, res_r;
  logic [2*N-1:0] prod;
  logic [2*N-2:0] nrm_r;
  logic st0_r, sign_r, g, st, inc, carry, r_ov, r_un, ov_inf;
  logic [2:0] rm_r;
  logic [EW+1:0] exp_r, exp_f;
  logic [3:0] fl_r, rnd_fl;
  logic [N:0] sum;
  assign {s1, e1, m1} = in1;
  assign {s2, e2, m2} = in2;
  assign nan1 = &e1 && |m1;
  assign nan2 = &e2 && |m2;
  assign inf1 = &e1 && ~|m1;
  assign inf2 = &e2 && ~|m2;
  assign zero1 = ~|e1;
  assign zero2 = ~|e2;
  assign special = nan1 | nan2 | inf1 | inf2 | zero1 | zero2;
  assign inv_op = (nan1 && !m1[MW-1]) || (nan2 && !m2[MW-1]) || (inf1 && zero2) || (zero1 && inf2);
  assign sp_res = (nan1 | nan2 | inv_op) ? W'(fp_pat(EW, MW, PAT_NAN, 1'b0)) :
    (inf1 | inf2) ? W'(fp_pat(EW, MW, PAT_INF, s1 ^ s2)) : {s1 ^ s2, (W-1)'(0)};
  assign busy = state != S_IDLE || done || mul_busy;
  assign accept = act && !busy;
  fp_mant_mul_seq #(.N(N)) u_mul (
    .clk(clk), .rst(rst), .start(accept && !special), .a({1'b1, m1}), .b({1'b1, m2}),
    .busy(mul_busy), .done(mul_done), .p(prod)
  );
  // nrm_r holds the hidden bit at 2N-2; everything below N-1 feeds guard/sticky
  assign g = nrm_r[N-2];
  assign st = |nrm_r[N-3:0] | st0_r;
  assign inc = rm_r == RM_RZ ? 1'b0 : rm_r == RM_RD ? sign_r & (g | st) :
    rm_r == RM_RU ? !sign_r & (g | st) : rm_r == RM_RMM ? g : g & (st | nrm_r[N-1]);
  assign sum = {1'b0, nrm_r[2*N-2:N-1]} + (N+1)'(inc);
  assign carry = sum[N];
  assign exp_f = exp_r + (EW+2)'(carry);
  assign r_ov = !exp_f[EW+1] && exp_f[EW:0] >= (EW+1)'(2 ** EW - 1);
  assign r_un = exp_f[EW+1] || exp_f == '0;
  assign ov_inf = rm_r == RM_RZ ? 1'b0 : rm_r == RM_RD ? sign_r : rm_r == RM_RU ? !sign_r : 1'b1;
  assign rnd_res = r_ov ? (ov_inf ? W'(fp_pat(EW, MW, PAT_INF, sign_r)) : W'(fp_pat(EW, MW, PAT_MAX, sign_r))) :
    r_un ? {sign_r, (W-1)'(0)} : {sign_r, exp_f[EW-1:0], carry ? sum[MW:1] : sum[MW-1:0]};
  assign rnd_fl = {r_ov, r_un, 1'b0, r_ov | r_un | g | st};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      done <= 1'b0;
      out <= '0;
      {ov, un, inv, inexact} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          sign_r <= s1 ^ s2;
          rm_r <= round_m;
          exp_r <= {2'b00, e1} + {2'b00, e2} - (EW+2)'(BIAS);
          res_r <= sp_res;
          fl_r <= {2'b00, inv_op, 1'b0};
          state <= special ? S_FIN : S_MUL;
        end
        S_MUL: if (mul_done) state <= S_NORM;
        S_NORM: begin
          nrm_r <= prod[2*N-1] ? prod[2*N-1:1] : prod[2*N-2:0];
          st0_r <= prod[2*N-1] & prod[0];
          exp_r <= exp_r + (EW+2)'(prod[2*N-1]);
          state <= S_RND;
        end
        S_RND: begin
          res_r <= rnd_res;
          fl_r <= rnd_fl;
          state <= S_FIN;
        end
        S_FIN: begin
          out <= res_r;
          {ov, un, inv, inexact} <= fl_r;
          done <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: scoreboard-driven bench for the sequential single-precision multiplier
module tb_fp_mul_seq;
  import fp_pkg::*;
  logic clk = 1'b0, rst = 1'b1, act = 1'b0;
  logic [31:0] in1 = '0, in2 = '0, out;
  logic [2:0] round_m = '0;
  logic busy, done, ov, un, inv, inexact;
  int checks = 0, errors = 0;
  typedef struct packed { logic [31:0] a, b; logic [2:0] rm; logic [31:0] res; logic [3:0] fl; } op_t;
  typedef struct packed { logic [31:0] res; logic [3:0] fl; logic [7:0] lat; } exp_t;
  exp_t sb[$];

  fp_mul_seq #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst), .act(act), .in1(in1), .in2(in2), .round_m(round_m),
    .busy(busy), .done(done), .out(out), .ov(ov), .un(un), .inv(inv), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic start_op(input op_t o, input logic [7:0] lat);
    @(negedge clk);
    in1 = o.a;
    in2 = o.b;
    round_m = o.rm;
    act = 1'b1;
    sb.push_back('{o.res, o.fl, lat});
    @(negedge clk);
    act = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 100);
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 2;
    if ({out, ov, un, inv, inexact} !== 36'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h/%b, want 0", out, {ov, un, inv, inexact});
    end
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset busy/done: got %b, want 00", {busy, done});
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    op_t t[11] = '{
      '{32'h3FC00000, 32'h40000000, RM_RNE, 32'h40400000, 4'b0000},
      '{32'h3F800001, 32'h3F800001, RM_RNE, 32'h3F800002, 4'b0001},
      '{32'h3F800001, 32'h3F800001, RM_RU,  32'h3F800003, 4'b0001},
      '{32'h3F800001, 32'h3F800001, RM_RZ,  32'h3F800002, 4'b0001},
      '{32'h3FC00000, 32'h3FC00001, RM_RNE, 32'h40100001, 4'b0001},
      '{32'h3FC00000, 32'h3FC00001, RM_RZ,  32'h40100000, 4'b0001},
      '{32'h3FC00000, 32'h3F800003, RM_RNE, 32'h3FC00004, 4'b0001},
      '{32'h3FC00000, 32'h3F800003, RM_RMM, 32'h3FC00005, 4'b0001},
      '{32'h3FC00000, 32'h3F800003, 3'd7,   32'h3FC00004, 4'b0001},
      '{32'h3F800001, 32'hBF800001, RM_RD,  32'hBF800003, 4'b0001},
      '{32'h3F800001, 32'hBF800001, RM_RU,  32'hBF800002, 4'b0001}
    };
    exp_t e;
    int lat;
    foreach (t[i]) begin
      start_op(t[i], 8'd27);
      wait_done(lat);
      e = sb.pop_front();
      checks += 2;
      if ({out, ov, un, inv, inexact} !== {e.res, e.fl}) begin
        errors++;
        $display("FAIL normal[%0d]: got %h flags %b, want %h flags %b", i, out, {ov, un, inv, inexact}, e.res, e.fl);
      end
      if (lat !== int'(e.lat)) begin
        errors++;
        $display("FAIL normal[%0d] latency: got %0d, want %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_special();
    op_t t[8] = '{
      '{32'h7F800000, 32'h00000000, RM_RNE, 32'h7FC00000, 4'b0010},
      '{32'h7F800001, 32'h3F800000, RM_RNE, 32'h7FC00000, 4'b0010},
      '{32'h7FC00000, 32'h3F800000, RM_RNE, 32'h7FC00000, 4'b0000},
      '{32'hFF800000, 32'h3F800000, RM_RZ,  32'hFF800000, 4'b0000},
      '{32'hFF800000, 32'hFF800000, RM_RNE, 32'h7F800000, 4'b0000},
      '{32'h80000000, 32'h3F800000, RM_RNE, 32'h80000000, 4'b0000},
      '{32'h00400000, 32'hBF800000, RM_RU,  32'h80000000, 4'b0000},
      '{32'h7F800000, 32'h80000000, RM_RNE, 32'h7FC00000, 4'b0010}
    };
    exp_t e;
    int lat;
    foreach (t[i]) begin
      start_op(t[i], 8'd1);
      wait_done(lat);
      e = sb.pop_front();
      checks += 2;
      if ({out, ov, un, inv, inexact} !== {e.res, e.fl}) begin
        errors++;
        $display("FAIL special[%0d]: got %h flags %b, want %h flags %b", i, out, {ov, un, inv, inexact}, e.res, e.fl);
      end
      if (lat !== int'(e.lat)) begin
        errors++;
        $display("FAIL special[%0d] latency: got %0d, want %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_range();
    op_t t[9] = '{
      '{32'h7F7FFFFF, 32'h40000000, RM_RZ,  32'h7F7FFFFF, 4'b1001},
      '{32'h7F7FFFFF, 32'h40000000, RM_RNE, 32'h7F800000, 4'b1001},
      '{32'h7F7FFFFF, 32'h40000000, RM_RD,  32'h7F7FFFFF, 4'b1001},
      '{32'h7F7FFFFF, 32'h40000000, RM_RU,  32'h7F800000, 4'b1001},
      '{32'hFF7FFFFF, 32'h40000000, RM_RD,  32'hFF800000, 4'b1001},
      '{32'hFF7FFFFF, 32'h40000000, RM_RU,  32'hFF7FFFFF, 4'b1001},
      '{32'hFF7FFFFF, 32'h40000000, RM_RMM, 32'hFF800000, 4'b1001},
      '{32'h00800000, 32'h3F000000, RM_RNE, 32'h00000000, 4'b0101},
      '{32'h80800000, 32'h3F000000, RM_RU,  32'h80000000, 4'b0101}
    };
    exp_t e;
    int lat;
    foreach (t[i]) begin
      start_op(t[i], 8'd27);
      wait_done(lat);
      e = sb.pop_front();
      checks += 2;
      if ({out, ov, un, inv, inexact} !== {e.res, e.fl}) begin
        errors++;
        $display("FAIL range[%0d]: got %h flags %b, want %h flags %b", i, out, {ov, un, inv, inexact}, e.res, e.fl);
      end
      if (lat !== int'(e.lat)) begin
        errors++;
        $display("FAIL range[%0d] latency: got %0d, want %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    @(negedge clk);
    in1 = 32'h3F800001; in2 = 32'h3F800001; round_m = RM_RU; act = 1'b1;
    sb.push_back('{32'h3F800003, 4'b0001, 8'd27});
    @(negedge clk);
    in1 = 32'h7F800000; in2 = 32'hC0000000; round_m = RM_RNE;
    sb.push_back('{32'hFF800000, 4'b0000, 8'd1});
    wait_done(lat);
    e = sb.pop_front();
    checks += 3;
    if ({out, ov, un, inv, inexact} !== {e.res, e.fl}) begin
      errors++;
      $display("FAIL b2b first: got %h flags %b, want %h flags %b", out, {ov, un, inv, inexact}, e.res, e.fl);
    end
    if (lat !== int'(e.lat)) begin
      errors++;
      $display("FAIL b2b first latency: got %0d, want %0d", lat, e.lat);
    end
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b busy in done cycle: got %b, want 1", busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b idle gap busy/done: got %b, want 00", {busy, done});
    end
    @(negedge clk);
    act = 1'b0;
    wait_done(lat);
    e = sb.pop_front();
    checks += 2;
    if ({out, ov, un, inv, inexact} !== {e.res, e.fl}) begin
      errors++;
      $display("FAIL b2b second: got %h flags %b, want %h flags %b", out, {ov, un, inv, inexact}, e.res, e.fl);
    end
    if (lat !== int'(e.lat)) begin
      errors++;
      $display("FAIL b2b second latency: got %0d, want %0d", lat, e.lat);
    end
  endtask

  task automatic test_busy_reset();
    exp_t e;
    int lat, n;
    start_op('{32'h3FC00000, 32'h40000000, RM_RNE, 32'h40400000, 4'b0000}, 8'd27);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy in flight: got %b, want 1", busy);
    end
    in1 = 32'h7F800000; in2 = 32'h00000000; act = 1'b1;
    @(negedge clk);
    act = 1'b0;
    wait_done(lat);
    e = sb.pop_front();
    checks += 2;
    if ({out, ov, un, inv, inexact} !== {e.res, e.fl}) begin
      errors++;
      $display("FAIL ignored act result: got %h flags %b, want %h flags %b", out, {ov, un, inv, inexact}, e.res, e.fl);
    end
    if (lat < 0 || lat + 5 !== int'(e.lat)) begin
      errors++;
      $display("FAIL ignored act latency: got %0d, want %0d", lat + 5, e.lat);
    end
    n = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) n++;
    end
    checks++;
    if (n !== 0 || out !== 32'h40400000) begin
      errors++;
      $display("FAIL extra done after ignored act: got %0d dones out %h, want 0 dones out 40400000", n, out);
    end
    start_op('{32'h3FC00000, 32'h3FC00001, RM_RNE, 32'h40100001, 4'b0001}, 8'd27);
    repeat (3) @(negedge clk);
    in1 = 32'h3F800000; in2 = 32'h00000000; act = 1'b1;
    @(negedge clk);
    act = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    n = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) n++;
    end
    checks += 2;
    if ({out, ov, un, inv, inexact, busy, done} !== 38'd0) begin
      errors++;
      $display("FAIL abort outputs: got %h flags %b busy %b done %b, want all 0", out, {ov, un, inv, inexact}, busy, done);
    end
    if (n !== 0) begin
      errors++;
      $display("FAIL abort done during reset: got %0d, want 0", n);
    end
    rst = 1'b0;
    in1 = 32'h3F800001; in2 = 32'h3F800001; round_m = RM_RU; act = 1'b1;
    sb.push_back('{32'h3F800003, 4'b0001, 8'd27});
    @(negedge clk);
    act = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept after reset: busy got %b, want 1", busy);
    end
    wait_done(lat);
    e = sb.pop_front();
    checks += 2;
    if ({out, ov, un, inv, inexact} !== {e.res, e.fl}) begin
      errors++;
      $display("FAIL post-reset op: got %h flags %b, want %h flags %b", out, {ov, un, inv, inexact}, e.res, e.fl);
    end
    if (lat !== int'(e.lat)) begin
      errors++;
      $display("FAIL post-reset latency: got %0d, want %0d", lat, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_back_to_back();
    test_busy_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
